// File: rtl/ysyx_22040237_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional perf counters are enabled by defining YSYX_22040237_IFU_PERF_CNT_EN.
package ysyx_22040237_ifu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        PC_KEEP     = 2'd0,
        PC_INC      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Payload presented to decode.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              fault;
    } fetch_pkt_t;

endpackage

// File: rtl/ysyx_22040237_ifu_pc.sv
// PC register with hold / +4 / redirect selection and redirect-target alignment check.
module ysyx_22040237_ifu_pc
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            misalign_c
);

    logic [XLEN-1:0] pc_n;

    // Next-PC mux; +4 wraps naturally at 2^XLEN.
    always_comb begin
        pc_n = pc;
        case (sel)
            PC_INC:      pc_n = pc + XLEN'(4);
            PC_REDIRECT: pc_n = redirect_pc;
            default:     pc_n = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_n;
        end
    end

    assign misalign_c = (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: one outstanding fetch, held instruction for decode, redirect/kill handling.
// Optional perf counters enabled by defining YSYX_22040237_IFU_PERF_CNT_EN.
module ysyx_22040237_ifu
    import ysyx_22040237_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_fault,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_kill_cnt
`endif
);

    ifu_state_e      state, state_n;
    logic            kill, kill_n;
    fetch_pkt_t      pkt_q, pkt_n;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc;
    logic            misalign_c;

    ysyx_22040237_ifu_pc #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .sel        (pc_sel),
        .redirect_pc(redirect_pc),
        .pc         (pc),
        .misalign_c (misalign_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_REQ;
            kill        <= 1'b0;
            pkt_q.inst  <= INST_NOP;
            pkt_q.pc    <= RESET_PC;
            pkt_q.fault <= 1'b0;
        end else begin
            state <= state_n;
            kill  <= kill_n;
            pkt_q <= pkt_n;
        end
    end

    // Redirect always wins; a misaligned target becomes a faulting held instruction with no fetch.
    always_comb begin
        state_n = state;
        kill_n  = kill;
        pkt_n   = pkt_q;
        pc_sel  = PC_KEEP;
        if (redirect_valid) begin
            pc_sel = PC_REDIRECT;
            if (misalign_c) begin
                state_n     = ST_HOLD;
                kill_n      = 1'b0;
                pkt_n.inst  = '0;
                pkt_n.pc    = redirect_pc;
                pkt_n.fault = 1'b1;
            end else begin
                case (state)
                    ST_REQ: begin
                        if (imem_req_ready) begin
                            state_n = ST_WAIT;
                            kill_n  = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rsp_valid) begin
                            state_n = ST_REQ;
                            kill_n  = 1'b0;
                        end else begin
                            kill_n = 1'b1;
                        end
                    end
                    default: state_n = ST_REQ;
                endcase
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_req_ready) state_n = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            state_n = ST_REQ;
                            kill_n  = 1'b0;
                        end else begin
                            state_n     = ST_HOLD;
                            pkt_n.inst  = imem_rsp_data;
                            pkt_n.pc    = pc;
                            pkt_n.fault = imem_rsp_err;
                        end
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        state_n = ST_REQ;
                        pc_sel  = PC_INC;
                    end
                end
                default: state_n = ST_REQ;
            endcase
        end
    end

    // Outputs read zero for as long as reset is held.
    assign imem_req_valid = ~rst & (state == ST_REQ);
    assign imem_req_addr  = rst ? '0 : pc;
    assign inst_valid     = ~rst & (state == ST_HOLD);
    assign inst           = rst ? '0 : pkt_q.inst;
    assign inst_pc        = rst ? '0 : pkt_q.pc;
    assign inst_fault     = ~rst & pkt_q.fault;

`ifdef YSYX_22040237_IFU_PERF_CNT_EN
    logic        fetch_fire_c;
    logic        kill_fire_c;
    logic [63:0] fetch_cnt_q;
    logic [63:0] kill_cnt_q;

    assign fetch_fire_c = (state == ST_HOLD) & inst_ready & ~redirect_valid;
    assign kill_fire_c  = (state == ST_WAIT) & imem_rsp_valid & (kill | redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (fetch_fire_c) fetch_cnt_q <= fetch_cnt_q + 64'd1;
            if (kill_fire_c)  kill_cnt_q  <= kill_cnt_q + 64'd1;
        end
    end

    assign perf_fetch_cnt = rst ? '0 : fetch_cnt_q;
    assign perf_kill_cnt  = rst ? '0 : kill_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// Directed + random bench for ysyx_22040237_ifu against a transaction-level fetch model.
module tb_ysyx_22040237_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_kill_cnt;
`endif

    ysyx_22040237_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .imem_rsp_err  (imem_rsp_err),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_fault    (inst_fault),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_kill_cnt (perf_kill_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus controls: 0 = hold low, 1 = hold high, 2 = random each cycle.
    bit          tb_rst     = 1'b1;
    int          ready_mode = 0;
    int          ir_mode    = 0;
    int          lat_lo     = 0;
    int          lat_hi     = 0;
    bit          rd_v       = 1'b0;
    logic [63:0] rd_pc      = '0;
    logic [63:0] err_addr   = 64'h1;

    // Memory: single response slot, counts down to the cycle it is presented.
    int          rsp_cnt = -1;
    logic [31:0] rsp_d   = '0;
    bit          rsp_e   = 1'b0;

    // Fetch model: busy = request accepted and unanswered; have = instruction offered to decode.
    logic [63:0] m_pc      = RST_PC;
    bit          m_busy    = 1'b0;
    bit          m_stale   = 1'b0;
    bit          m_have    = 1'b0;
    logic [31:0] m_inst    = '0;
    logic [63:0] m_ipc     = '0;
    bit          m_fault   = 1'b0;
    longint unsigned m_fetches = 0;
    longint unsigned m_kills   = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RST_PC) return 32'h0010_0093;
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance memory and model.
    task automatic tick();
        bit          rdy;
        bit          irdy;
        bit          rsp_now;
        logic [31:0] rsp_d_now;
        bit          rsp_e_now;
        bit          m_req;
        rdy  = (ready_mode == 2) ? bit'($urandom_range(0, 1)) : (ready_mode == 1);
        irdy = (ir_mode == 2) ? bit'($urandom_range(0, 1)) : (ir_mode == 1);
        rsp_now   = (rsp_cnt == 0);
        rsp_d_now = rsp_now ? rsp_d : 32'($urandom);
        rsp_e_now = rsp_now ? rsp_e : 1'b0;

        rst            = tb_rst;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = rd_v;
        redirect_pc    = rd_v ? rd_pc : {32'($urandom), 32'($urandom)};
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_d_now;
        imem_rsp_err   = rsp_e_now;
        #1;

        if (tb_rst) begin
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_req_addr", imem_req_addr, 64'h0);
            chk1("rst_inst_valid", inst_valid, 1'b0);
            chk("rst_inst", 64'(inst), 64'h0);
            chk("rst_inst_pc", inst_pc, 64'h0);
            chk1("rst_inst_fault", inst_fault, 1'b0);
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
            chk("rst_perf_fetch", perf_fetch_cnt, 64'h0);
            chk("rst_perf_kill", perf_kill_cnt, 64'h0);
`endif
        end else begin
            chk1("req_valid", imem_req_valid, !m_busy && !m_have);
            if (!m_busy && !m_have) chk("req_addr", imem_req_addr, m_pc);
            chk1("inst_valid", inst_valid, m_have);
            if (m_have) begin
                chk("inst", 64'(inst), 64'(m_inst));
                chk("inst_pc", inst_pc, m_ipc);
                chk1("inst_fault", inst_fault, m_fault);
            end
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
            chk("perf_fetch", perf_fetch_cnt, 64'(m_fetches));
            chk("perf_kill", perf_kill_cnt, 64'(m_kills));
`endif
        end

        m_req = !tb_rst && !m_busy && !m_have;
        if (rsp_cnt > 0) rsp_cnt--;
        else if (rsp_cnt == 0) rsp_cnt = -1;
        if (m_req && rdy) begin
            rsp_cnt = $urandom_range(lat_lo, lat_hi);
            rsp_d   = mem_word(m_pc);
            rsp_e   = (m_pc == err_addr);
        end

        if (tb_rst) begin
            m_pc = RST_PC; m_busy = 0; m_stale = 0; m_have = 0;
            m_fetches = 0; m_kills = 0;
        end else if (rd_v) begin
            if (m_busy && rsp_now) m_kills++;
            if (rd_pc[1:0] != 2'b00) begin
                m_have = 1; m_inst = '0; m_fault = 1; m_ipc = rd_pc;
                m_busy = 0; m_stale = 0;
            end else if (m_have) begin
                m_have = 0;
            end else if (m_busy) begin
                if (rsp_now) begin m_busy = 0; m_stale = 0; end
                else m_stale = 1;
            end else if (rdy) begin
                m_busy = 1; m_stale = 1;
            end
            m_pc = rd_pc;
        end else if (m_have) begin
            if (irdy) begin m_have = 0; m_pc = m_pc + 64'd4; m_fetches++; end
        end else if (m_busy) begin
            if (rsp_now) begin
                m_busy = 0;
                if (m_stale) begin
                    m_stale = 0; m_kills++;
                end else begin
                    m_have = 1; m_inst = rsp_d_now; m_fault = rsp_e_now; m_ipc = m_pc;
                end
            end
        end else if (rdy) begin
            m_busy = 1;
        end

        rd_v = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input string tag, input logic [31:0] ei, input logic [63:0] ep,
                             input logic ef, input int budget);
        int n = 0;
        while (inst_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk1({tag, "_valid"}, inst_valid, 1'b1);
        chk({tag, "_inst"}, 64'(inst), 64'(ei));
        chk({tag, "_pc"}, inst_pc, ep);
        chk1({tag, "_fault"}, inst_fault, ef);
    endtask

    task automatic wait_req(input string tag, input logic [63:0] ea, input int budget);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk1({tag, "_valid"}, imem_req_valid, 1'b1);
        chk({tag, "_addr"}, imem_req_addr, ea);
    endtask

    logic [31:0] held_inst;
    logic [63:0] held_pc;

    initial begin
        rst = 1'b1; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        imem_rsp_err = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = '0;
        @(posedge clk);
        #1;

        // Reset, then first fetch with zero-latency memory.
        tb_rst = 1; repeat (3) tick();
        tb_rst = 0; ready_mode = 1; lat_lo = 0; lat_hi = 0; ir_mode = 1;
        wait_hold("first", 32'h0010_0093, RST_PC, 1'b0, 10);
        tick();
        chk1("next_req_valid", imem_req_valid, 1'b1);
        chk("next_req_addr", imem_req_addr, RST_PC + 64'd4);

        // Decode stalls five cycles in HOLD.
        ir_mode = 0;
        wait_hold("stall", mem_word(RST_PC + 64'd4), RST_PC + 64'd4, 1'b0, 10);
        held_inst = inst; held_pc = inst_pc;
        repeat (5) tick();
        chk("stall_inst_stable", 64'(inst), 64'(mem_word(RST_PC + 64'd4)));
        chk("stall_pc_stable", inst_pc, RST_PC + 64'd4);
        chk1("stall_no_req", imem_req_valid, 1'b0);
        ir_mode = 1;
        tick();
        chk1("after_stall_req", imem_req_valid, 1'b1);
        chk("after_stall_addr", imem_req_addr, held_pc + 64'd4);

        // Redirect while waiting; stale response arrives later.
        lat_lo = 3; lat_hi = 3;
        tick();
        rd_v = 1; rd_pc = 64'h8000_0100;
        tick();
        wait_req("redir_req", 64'h8000_0100, 10);
        wait_hold("redir_hold", mem_word(64'h8000_0100), 64'h8000_0100, 1'b0, 20);

        // Redirect and inst_ready in the same HOLD cycle.
        lat_lo = 0; lat_hi = 0;
        rd_v = 1; rd_pc = 64'h8000_0200;
        tick();
        chk1("rdh_inst_valid", inst_valid, 1'b0);
        chk1("rdh_req_valid", imem_req_valid, 1'b1);
        chk("rdh_req_addr", imem_req_addr, 64'h8000_0200);
`ifdef YSYX_22040237_IFU_PERF_CNT_EN
        chk("rdh_perf_fetch", perf_fetch_cnt, 64'd2);
        chk("rdh_perf_kill", perf_kill_cnt, 64'd1);
`endif

        // Misaligned redirect target.
        ready_mode = 0;
        rd_v = 1; rd_pc = 64'h8000_0102;
        tick();
        chk1("mis_no_req", imem_req_valid, 1'b0);
        chk1("mis_inst_valid", inst_valid, 1'b1);
        chk("mis_inst", 64'(inst), 64'h0);
        chk1("mis_fault", inst_fault, 1'b1);
        chk("mis_pc", inst_pc, 64'h8000_0102);
        tick();
        chk("mis_next_addr", imem_req_addr, 64'h8000_0106);

        // Access fault reported with the response.
        rd_v = 1; rd_pc = 64'h8000_0300;
        tick();
        err_addr = 64'h8000_0300; ready_mode = 1;
        wait_hold("acc_err", mem_word(64'h8000_0300), 64'h8000_0300, 1'b1, 10);

        // Reset in the middle of WAIT; the late response must be ignored.
        lat_lo = 3; lat_hi = 3;
        tick(); tick(); tick();
        tb_rst = 1; ready_mode = 0;
        tick(); tick();
        tb_rst = 0;
        tick();
        chk1("post_rst_req", imem_req_valid, 1'b1);
        chk("post_rst_addr", imem_req_addr, RST_PC);
        chk1("post_rst_no_inst", inst_valid, 1'b0);
        ready_mode = 1; lat_lo = 0; lat_hi = 0;
        wait_hold("post_rst", 32'h0010_0093, RST_PC, 1'b0, 10);

        // PC wraps modulo 2^64.
        tick();
        ready_mode = 0;
        rd_v = 1; rd_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        ready_mode = 1;
        wait_hold("wrap", mem_word(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 10);
        tick();
        chk1("wrap_req", imem_req_valid, 1'b1);
        chk("wrap_addr", imem_req_addr, 64'h0);

        // Random traffic: ready, decode stalls, latency and redirects.
        ready_mode = 2; ir_mode = 2; lat_lo = 0; lat_hi = 3; err_addr = 64'h8000_0040;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rd_v = 1; rd_pc = RST_PC + 64'($urandom_range(0, 63)) * 64'd4;
            end else if (r == 1 && m_have) begin
                rd_v = 1; rd_pc = RST_PC + 64'($urandom_range(0, 63)) * 64'd4 + 64'($urandom_range(1, 3));
            end
            tick();
        end

        $display("model transfers=%0d dropped=%0d", m_fetches, m_kills);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
